// File: rtl/dz_dtr_ctl.sv
// DZ11 DTR output controller: TCR high-byte request register, 1 ms prescaler and
// a per-line OFF/ON/HOLD machine that enforces a minimum DTR-low hang-up time.
module dz_dtr_ctl #(
  parameter int CLKFRQ    = 20000000,
  parameter int HANGUP_MS = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       tcrWR,
  input  logic [7:0] tcrDATA,
  output logic [7:0] regDTR,
  output logic [7:0] dzDTR,
  output logic [7:0] dtrHOLD
);

  localparam int P  = CLKFRQ / 1000;
  localparam int PW = (P > 1) ? $clog2(P) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(P - 1);
  localparam logic [9:0]    HANG_CNT = 10'(HANGUP_MS);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_ON   = 2'd1,
    ST_HOLD = 2'd2
  } line_state_e;

  logic [7:0]    reg_q, reg_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          tick;
  line_state_e   state_q [8];
  line_state_e   state_d [8];
  logic [9:0]    cnt_q [8];
  logic [9:0]    cnt_d [8];

  assign tick = (pre_q == PRE_LAST);

  always_comb begin
    reg_d = reg_q;
    pre_d = tick ? '0 : pre_q + PW'(1);
    // clr wins over a simultaneous write; lines then fall into HOLD via reg_q.
    if (clr) begin
      reg_d = '0;
    end else if (tcrWR) begin
      reg_d = tcrDATA;
    end
    for (int n = 0; n < 8; n++) begin
      state_d[n] = state_q[n];
      cnt_d[n]   = cnt_q[n];
      case (state_q[n])
        ST_OFF: begin
          if (reg_q[n]) state_d[n] = ST_ON;
        end
        ST_ON: begin
          if (!reg_q[n]) begin
            state_d[n] = ST_HOLD;
            cnt_d[n]   = HANG_CNT;
          end
        end
        ST_HOLD: begin
          // A reassert during the hold is only honoured once the count expires.
          if (cnt_q[n] == 10'd0) begin
            state_d[n] = reg_q[n] ? ST_ON : ST_OFF;
          end else if (tick) begin
            cnt_d[n] = cnt_q[n] - 10'd1;
          end
        end
        default: begin
          state_d[n] = ST_OFF;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_q <= '0;
      pre_q <= '0;
      for (int n = 0; n < 8; n++) begin
        state_q[n] <= ST_OFF;
        cnt_q[n]   <= '0;
      end
    end else begin
      reg_q <= reg_d;
      pre_q <= pre_d;
      for (int n = 0; n < 8; n++) begin
        state_q[n] <= state_d[n];
        cnt_q[n]   <= cnt_d[n];
      end
    end
  end

  always_comb begin
    for (int n = 0; n < 8; n++) begin
      dzDTR[n]   = (state_q[n] == ST_ON);
      dtrHOLD[n] = (state_q[n] == ST_HOLD);
    end
  end

  assign regDTR = reg_q;

endmodule

// File: tb/tb_dz_dtr_ctl.sv
// Bench for dz_dtr_ctl: directed scenarios plus random traffic on two instances
// (hang-up of 3 ms and of 0 ms) checked against a closed-form hold-timing model.
module tb_dz_dtr_ctl;

  localparam int CLKFRQ = 10000;
  localparam int P      = CLKFRQ / 1000;
  localparam int H_A    = 3;
  localparam int H_B    = 0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr_a = 1'b0, wr_a = 1'b0;
  logic [7:0] data_a = 8'h00;
  logic       clr_b = 1'b0, wr_b = 1'b0;
  logic [7:0] data_b = 8'h00;
  logic [7:0] reg_a, dz_a, hold_a;
  logic [7:0] reg_b, dz_b, hold_b;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 = off, 1 = on, 2 = hang-up hold ending at exit_m.
  logic [7:0] reg_m  [2];
  int         mode_m [2][8];
  longint     exit_m [2][8];
  int         pre_m;
  longint     edge_n = 0;

  dz_dtr_ctl #(.CLKFRQ(CLKFRQ), .HANGUP_MS(H_A)) u_dut_a (
    .clk(clk), .rst(rst), .clr(clr_a), .tcrWR(wr_a), .tcrDATA(data_a),
    .regDTR(reg_a), .dzDTR(dz_a), .dtrHOLD(hold_a)
  );

  dz_dtr_ctl #(.CLKFRQ(CLKFRQ), .HANGUP_MS(H_B)) u_dut_b (
    .clk(clk), .rst(rst), .clr(clr_b), .tcrWR(wr_b), .tcrDATA(data_b),
    .regDTR(reg_b), .dzDTR(dz_b), .dtrHOLD(hold_b)
  );

  always #5 clk = ~clk;

  // Edge at which a hold entered at this edge ends: H ticks must pass after
  // entry, and the expiry is seen one edge after the last tick.
  function automatic longint hold_exit(input int h, input int pre_now, input longint e);
    int j1;
    if (h == 0) return e + 1;
    j1 = P - 1 - pre_now;
    if (j1 == 0) j1 = P;
    return e + j1 + (h - 1) * P + 1;
  endfunction

  task automatic model_step(input int i, input int h, input logic c, input logic w,
                            input logic [7:0] d);
    for (int n = 0; n < 8; n++) begin
      if (mode_m[i][n] == 0) begin
        if (reg_m[i][n]) mode_m[i][n] = 1;
      end else if (mode_m[i][n] == 1) begin
        if (!reg_m[i][n]) begin
          mode_m[i][n] = 2;
          exit_m[i][n] = hold_exit(h, pre_m, edge_n);
        end
      end else if (edge_n == exit_m[i][n]) begin
        mode_m[i][n] = reg_m[i][n] ? 1 : 0;
      end
    end
    if (c) reg_m[i] = 8'h00;
    else if (w) reg_m[i] = d;
  endtask

  always @(posedge clk) begin
    edge_n++;
    if (rst) begin
      pre_m = 0;
      for (int i = 0; i < 2; i++) begin
        reg_m[i] = 8'h00;
        for (int n = 0; n < 8; n++) mode_m[i][n] = 0;
      end
    end else begin
      model_step(0, H_A, clr_a, wr_a, data_a);
      model_step(1, H_B, clr_b, wr_b, data_b);
      pre_m = (pre_m == P - 1) ? 0 : pre_m + 1;
    end
  end

  function automatic logic [7:0] exp_mask(input int i, input int m);
    logic [7:0] r;
    for (int n = 0; n < 8; n++) r[n] = (mode_m[i][n] == m);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: inputs set by the caller are taken at the posedge, outputs
  // are compared against the model on the following negedge.
  task automatic step();
    @(negedge clk);
    chk("reg_a",  {24'h0, reg_a},  {24'h0, reg_m[0]});
    chk("dz_a",   {24'h0, dz_a},   {24'h0, exp_mask(0, 1)});
    chk("hold_a", {24'h0, hold_a}, {24'h0, exp_mask(0, 2)});
    chk("reg_b",  {24'h0, reg_b},  {24'h0, reg_m[1]});
    chk("dz_b",   {24'h0, dz_b},   {24'h0, exp_mask(1, 1)});
    chk("hold_b", {24'h0, hold_b}, {24'h0, exp_mask(1, 2)});
  endtask

  task automatic write_a(input logic [7:0] d);
    wr_a = 1'b1; data_a = d;
    step();
    wr_a = 1'b0;
  endtask

  task automatic write_b(input logic [7:0] d);
    wr_b = 1'b1; data_b = d;
    step();
    wr_b = 1'b0;
  endtask

  initial begin
    int n;
    int pulses;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 8; k++) exit_m[i][k] = 0;

    // Reset values
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_reg", {24'h0, reg_a}, 32'h00);
    chk("rst_dz", {24'h0, dz_a}, 32'h00);
    chk("rst_hold", {24'h0, hold_a}, 32'h00);

    // Set with two-cycle write-to-pin latency
    write_a(8'hA5);
    chk("set_reg", {24'h0, reg_a}, 32'hA5);
    chk("set_dz_early", {24'h0, dz_a}, 32'h00);
    step();
    chk("set_dz", {24'h0, dz_a}, 32'hA5);
    chk("set_hold", {24'h0, hold_a}, 32'h00);

    // Hang-up of line 7 from all-on
    write_a(8'hFF);
    step();
    chk("all_on", {24'h0, dz_a}, 32'hFF);
    write_a(8'h7F);
    step();
    chk("hup_dz", {24'h0, dz_a}, 32'h7F);
    chk("hup_hold", {24'h0, hold_a}, 32'h80);
    n = 1;
    while (hold_a[7] && n < 100) begin
      step();
      if (hold_a[7]) n++;
    end
    chk("hup_len_ok", {31'h0, (n >= (H_A - 1) * P + 2) && (n <= H_A * P + 1)}, 32'h1);
    chk("hup_end_hold", {24'h0, hold_a}, 32'h00);
    chk("hup_end_dz", {24'h0, dz_a}, 32'h7F);

    // Reassert in hold; rewrites during hold must not extend it
    write_a(8'h00);
    step();
    repeat (3) step();
    write_a(8'h01);
    chk("rea_reg", {24'h0, reg_a}, 32'h01);
    chk("rea_dz", {24'h0, dz_a}, 32'h00);
    n = 0;
    while (hold_a[0] && n < 100) begin
      if (n % 3 == 0) write_a(8'h01);
      else step();
      n++;
    end
    chk("rea_done", {31'h0, n < 100}, 32'h1);
    chk("rea_dz_up", {31'h0, dz_a[0]}, 32'h1);

    // Master clear with simultaneous write: every on line enters hold
    write_a(8'hFF);
    n = 0;
    while (dz_a != 8'hFF && n < 100) begin
      step();
      n++;
    end
    chk("clr_pre_all_on", {24'h0, dz_a}, 32'hFF);
    clr_a = 1'b1; wr_a = 1'b1; data_a = 8'hFF;
    step();
    clr_a = 1'b0; wr_a = 1'b0;
    chk("clr_reg", {24'h0, reg_a}, 32'h00);
    step();
    chk("clr_hold", {24'h0, hold_a}, 32'hFF);
    chk("clr_dz", {24'h0, dz_a}, 32'h00);

    // Reset mid-hold leaves no residual hold
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rmh_hold", {24'h0, hold_a}, 32'h00);
    chk("rmh_dz", {24'h0, dz_a}, 32'h00);
    write_a(8'h01);
    step();
    chk("rmh_dz1", {24'h0, dz_a}, 32'h01);
    chk("rmh_hold1", {24'h0, hold_a}, 32'h00);

    // Zero hang-up: single-cycle hold pulse
    write_b(8'h01);
    write_b(8'h00);
    write_b(8'h01);
    pulses = hold_b[0] ? 1 : 0;
    repeat (5) begin
      step();
      if (hold_b[0]) pulses++;
    end
    chk("h0_pulse", pulses, 1);
    chk("h0_dz", {31'h0, dz_b[0]}, 32'h1);

    // Random traffic on both instances
    for (int c = 0; c < 4000; c++) begin
      rst    = ($urandom_range(0, 599) == 0);
      clr_a  = ($urandom_range(0, 79) == 0);
      clr_b  = ($urandom_range(0, 79) == 0);
      wr_a   = ($urandom_range(0, 11) == 0);
      wr_b   = ($urandom_range(0, 3) == 0);
      data_a = 8'($urandom_range(0, 255));
      data_b = 8'($urandom_range(0, 255));
      step();
    end
    rst = 1'b0; clr_a = 1'b0; clr_b = 1'b0; wr_a = 1'b0; wr_b = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dz_dtr_ctl.md
# dz_dtr_ctl

DZ11 Data Terminal Ready (DTR) output controller: the modem-control output side of the DZ11, complementing the carrier/ring status input path. It holds the eight DTR request bits written through the high byte of the Transmit Control Register (TCR) and drives the per-line DTR outputs toward the modem interface. Each line has a hang-up guard: once DTR drops, it is held low for a minimum time before it can be reasserted. The block sits between the DZ11 register decode and the external modem/line pins.

## Interface
- CLKFRQ, 20000000: clock frequency in Hz; the prescaler period is P = CLKFRQ/1000 cycles (1 ms tick).
- HANGUP_MS, 500: minimum DTR-low hold time in ticks. Range 0..1023.
- clk  input  1  clock
- rst  input  1  reset: synchronous, active-high
- clr  input  1  DZ11 master clear (CSR CLR); single-cycle, synchronous
- tcrWR  input  1  write strobe for the TCR high byte
- tcrDATA  input  8  DTR request bits, bit n = line n
- regDTR  output  8  requested DTR bits (TCR[15:8] readback)
- dzDTR  output  8  DTR to modem interface, bit n = line n
- dtrHOLD  output  8  line n is in hang-up hold

## Operation
- Request register regDTR: on rst it loads 0; on clr it loads 0 (clr takes priority over tcrWR in the same cycle); on tcrWR it loads tcrDATA; otherwise it holds.
- Prescaler: free-running counter 0..P-1, cleared by rst (not by clr). It emits a one-cycle tick when the count equals P-1, then wraps to 0.
- Per-line FSM with states OFF, ON and HOLD, plus a 10-bit down-counter cnt[n]. Transitions are evaluated every cycle from the registered regDTR[n]:
  - OFF: if regDTR[n]=1, go to ON.
  - ON: if regDTR[n]=0, go to HOLD and load cnt[n]=HANGUP_MS.
  - HOLD: if cnt[n]=0, go to ON when regDTR[n]=1, else go to OFF. Otherwise, decrement cnt[n] on each tick.
- Outputs: dzDTR[n]=1 only in ON. dtrHOLD[n]=1 only in HOLD.
- Reassert during HOLD: the write is latched in regDTR, but dzDTR stays low until the hold expires.
- Writing 0 to a line already OFF or HOLD does not start or restart a hold. Toggling 1→0→1 while in HOLD does not reload cnt.
- clr: every line in ON enters HOLD through the normal FSM path, so hang-up timing is honoured.
- rst: all lines go to OFF and all cnt go to 0, with no hold. This applies even mid-hold.
- HANGUP_MS=0: HOLD lasts exactly one cycle, because cnt=0 on the next evaluation.
- Lines are fully independent; simultaneous transitions on any subset of lines are legal.

## Timing
- Reset values: regDTR=0x00, dzDTR=0x00, dtrHOLD=0x00, prescaler=0.
- tcrWR sampled at edge N: regDTR is valid after edge N, and dzDTR/dtrHOLD are valid after edge N+1 (2-cycle write-to-pin latency).
- Hold duration, measured as dzDTR low from the ON→HOLD edge until the exit from HOLD:
  - at least (HANGUP_MS−1)·P+2 cycles
  - at most HANGUP_MS·P+1 cycles
  - the exact value depends on prescaler phase.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset/set, with CLKFRQ=10000 (P=10) and HANGUP_MS=3:
  - after rst, all outputs = 0x00.
  - write tcrDATA=0xA5 → regDTR=0xA5 after 1 cycle, then dzDTR=0xA5 one cycle later, dtrHOLD=0x00.
- Hang-up: from dzDTR=0xFF, write 0x7F:
  - dzDTR=0x7F and dtrHOLD=0x80 two cycles after the write.
  - the hold lasts 22..31 cycles, then dtrHOLD=0x00 and dzDTR stays 0x7F.
- Reassert in hold: write 0x00, then 0x01 five cycles later:
  - regDTR=0x01 immediately.
  - dzDTR[0] stays 0 until the hold expires, then goes to 1 in the same cycle dtrHOLD[0] clears.
  - repeated writes during HOLD do not extend it.
- clr with tcrWR=0xFF in the same cycle: regDTR=0x00, and every previously-ON line enters HOLD.
- rst mid-hold: all states go to OFF, dtrHOLD=0x00, and a following write 0x01 gives dzDTR=0x01 after 2 cycles with no residual hold.
- HANGUP_MS=0: write 0x01, 0x00, 0x01 on consecutive cycles → dtrHOLD[0] pulses for exactly 1 cycle, then dzDTR[0] returns to 1.
